// File: rtl/sgde_pkg.sv
// Shared constants and types for the frame-buffer scanout block.
// Holds the FSM state enum, default geometry and FIFO depth.
package sgde_pkg;

  localparam int FB_DEPTH_DEF = 4096;
  localparam int PIX_W_DEF    = 12;
  localparam int LINE_W_DEF   = 64;
  localparam int FIFO_DEPTH   = 2;
  localparam int AW           = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/fb_scan_fifo.sv
// Two-entry FIFO carrying {address, pixel} from FB read to the consumer.
// Push and pop on the same edge are allowed, even when full.
module fb_scan_fifo
  import sgde_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_in;
  logic         w_out;

  assign o_full  = (r_cnt == 2'(FIFO_DEPTH));
  assign o_empty = (r_cnt == 2'd0);
  assign w_out   = i_pop & ~o_empty;
  assign w_in    = i_push & (~o_full | w_out);
  assign o_dout  = r_mem[r_rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_in) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_out) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_in) - 2'(w_out);
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: streams FB words out as pixels with x/y coords.
// Optional frame checksum output enabled by FB_SCAN_CKSUM_EN.
module fb_scanout
  import sgde_pkg::*;
#(
  parameter int FB_DEPTH = FB_DEPTH_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LINE_W   = LINE_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             FB_CEN,
  output logic             FB_WEN,
  output logic [AW-1:0]    FB_A,
  input  logic [PIX_W-1:0] FB_Q,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [5:0]       pix_x,
  output logic [5:0]       pix_y,
  output logic             busy,
  output logic             frame_done
`ifdef FB_SCAN_CKSUM_EN
  ,
  output logic [15:0]      cksum
`endif
);

  localparam int DW = PIX_W + AW;
  localparam int XW = $clog2(LINE_W);

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_infl_addr;
  logic            r_infl;
  logic            r_done;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_issue;
  logic [1:0]      w_occ;
  logic [1:0]      w_load;
  logic [DW-1:0]   w_head;
  logic [AW-1:0]   w_haddr;

  assign w_pop   = pix_valid & pix_ready;
  assign w_occ   = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
  // A same-cycle pop frees a slot, which keeps the 1 pixel/cycle rate.
  assign w_load  = w_occ + {1'b0, r_infl} - {1'b0, w_pop};
  assign w_issue = (r_state == S_READ) && (w_load < 2'd2);

  assign FB_CEN     = ~w_issue;
  assign FB_WEN     = 1'b1;
  assign FB_A       = r_addr;
  assign pix_valid  = ~w_empty;
  assign pix_data   = w_head[PIX_W-1:0];
  assign w_haddr    = w_head[DW-1:PIX_W];
  assign pix_x      = 6'(w_haddr & AW'(LINE_W - 1));
  assign pix_y      = 6'(w_haddr >> XW);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

  fb_scan_fifo #(.W(DW)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_infl),
    .i_din  ({r_infl_addr, FB_Q}),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_infl_addr <= '0;
      r_infl      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_addr <= r_addr;
        r_addr      <= r_addr + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_addr  <= '0;
          end
        end
        S_READ: begin
          if (w_issue && r_addr == AW'(FB_DEPTH - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && w_occ == 2'd1 && !r_infl) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FB_SCAN_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cksum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cksum <= '0;
    end else if (w_pop) begin
      r_cksum <= r_cksum + 16'(pix_data);
    end
  end

  assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout with a random-ready reference model.
// Define FB_SCAN_CKSUM_EN to also check the checksum output.
module tb_fb_scanout;
  import sgde_pkg::*;

  localparam int D = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        FB_CEN, FB_WEN, pix_valid, busy, frame_done;
  logic [11:0] FB_A, pix_data;
  logic [11:0] FB_Q = '0;
  logic [5:0]  pix_x, pix_y;
`ifdef FB_SCAN_CKSUM_EN
  logic [15:0] cksum;
  logic [15:0] exp_ck;
`endif

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .FB_CEN    (FB_CEN),
    .FB_WEN    (FB_WEN),
    .FB_A      (FB_A),
    .FB_Q      (FB_Q),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef FB_SCAN_CKSUM_EN
    ,
    .cksum     (cksum)
`endif
  );

  typedef struct packed {
    logic [11:0] d;
    logic [5:0]  x;
    logic [5:0]  y;
  } pix_t;

  pix_t        exp_q[$];
  logic [11:0] mem[D];
  int          vec = 0;
  int          bad = 0;
  int          edge_n = 0;
  int          t0 = 0;
  int          issued = 0;
  int          acc = 0;
  int          acc0 = 0;
  int          done_cnt = 0;
  int          rmode = 0;
  bit          lat_chk = 0;
  bit          seen_first = 0;
  bit          prev_stall = 0;
  bit          prev_done = 0;
  pix_t        prev_pix;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!FB_CEN) FB_Q <= mem[FB_A];
  end

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    vec++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    int   outst;
    int   pop;
    pix_t cur;
    pix_t e;
    if (reset) begin
      exp_q.delete();
      issued = 0;
      acc = 0;
      prev_stall = 0;
      prev_done = 0;
    end else begin
      cur = {pix_data, pix_x, pix_y};
      pop = (pix_valid && pix_ready) ? 1 : 0;
      outst = issued - acc;
      chk(FB_WEN == 1'b1, "fb_wen", FB_WEN, 1);
      chk(outst + (FB_CEN ? 0 : 1) - pop <= 2, "overrun",
          outst + (FB_CEN ? 0 : 1) - pop, 2);
      if (outst == 2 && !pix_ready)
        chk(FB_CEN == 1'b1, "cen_when_full", FB_CEN, 1);
      if (!FB_CEN) begin
        chk(FB_A == 12'(issued % D), "fb_a", FB_A, issued % D);
        issued++;
      end
      if (prev_stall)
        chk(pix_valid && cur == prev_pix, "stall_hold", cur, prev_pix);
      if (lat_chk && !seen_first && pix_valid) begin
        chk(edge_n - t0 == 2, "first_pix_edge", edge_n - t0, 2);
        seen_first = 1;
      end
      if (pop == 1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_pixel", cur, 0);
        end else begin
          e = exp_q.pop_front();
          chk(cur == e, "pixel", cur, e);
          if (acc % D == 130) begin
            chk(pix_x == 6'd2, "x_at_130", pix_x, 2);
            chk(pix_y == 6'd2, "y_at_130", pix_y, 2);
          end
        end
        acc++;
      end
      if (frame_done) begin
        done_cnt++;
        chk(!prev_done, "done_one_cycle", prev_done, 0);
        chk(!busy, "busy_fall", busy, 0);
        chk(exp_q.size() == 0, "all_pixels", exp_q.size(), 0);
        if (lat_chk)
          chk(edge_n - t0 == 4098, "done_edge", edge_n - t0, 4098);
`ifdef FB_SCAN_CKSUM_EN
        chk(cksum == exp_ck, "cksum", cksum, exp_ck);
`endif
      end
      prev_done = frame_done;
      prev_stall = pix_valid && !pix_ready;
      prev_pix = cur;
    end
  end

  task automatic fill(input bit rnd);
    for (int a = 0; a < D; a++)
      mem[a] = rnd ? 12'($urandom) : 12'(a);
  endtask

  task automatic push_frame();
`ifdef FB_SCAN_CKSUM_EN
    exp_ck = '0;
`endif
    for (int a = 0; a < D; a++) begin
      exp_q.push_back(pix_t'{mem[a], 6'(a % 64), 6'(a / 64)});
`ifdef FB_SCAN_CKSUM_EN
      exp_ck = exp_ck + 16'(mem[a]);
`endif
    end
  endtask

  task automatic do_start(input bit accepted);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (accepted) push_frame();
    @(posedge clk);
    #1;
    if (accepted) begin
      t0 = edge_n;
      seen_first = 0;
      acc0 = acc;
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(done_cnt != d0, "done_timeout", n, budget);
  endtask

  task automatic wait_pix(input int num, input int budget);
    int n = 0;
    while (acc - acc0 < num && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(acc - acc0 >= num, "pix_timeout", acc - acc0, num);
  endtask

  task automatic chk_reset_vals();
    chk(FB_CEN == 1'b1, "rst_cen", FB_CEN, 1);
    chk(FB_WEN == 1'b1, "rst_wen", FB_WEN, 1);
    chk(FB_A == 12'd0, "rst_a", FB_A, 0);
    chk(pix_valid == 1'b0, "rst_valid", pix_valid, 0);
    chk({pix_data, pix_x, pix_y} == 24'd0, "rst_pix",
        {pix_data, pix_x, pix_y}, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(frame_done == 1'b0, "rst_done", frame_done, 0);
  endtask

  initial begin
    int i0;
    int d0;
    #3 reset = 1'b1;
    #2 chk_reset_vals();
    #20;
    @(posedge clk);
    #1 reset = 1'b0;

    fill(1'b0);
    rmode = 0;
    lat_chk = 1;
    do_start(1'b1);
    wait_done(5000);
    lat_chk = 0;
    repeat (3) @(posedge clk);
`ifdef FB_SCAN_CKSUM_EN
    #1 chk(cksum == 16'hF800, "cksum_held", cksum, 16'hF800);
`endif

    fill(1'b1);
    rmode = 1;
    do_start(1'b1);
    wait_done(20000);

    fill(1'b1);
    rmode = 3;
    i0 = issued;
    do_start(1'b1);
    repeat (100) @(posedge clk);
    chk(issued - i0 == 2, "stall_reads", issued - i0, 2);
    rmode = 2;
    wait_done(20000);

    fill(1'b1);
    rmode = 2;
    do_start(1'b1);
    wait_pix(1000, 5000);
    d0 = done_cnt;
    do_start(1'b0);
    chk(busy == 1'b1, "busy_mid", busy, 1);
    wait_done(20000);
    repeat (50) @(posedge clk);
    chk(done_cnt - d0 == 1, "one_done", done_cnt - d0, 1);
    chk(acc - acc0 == D, "pix_count", acc - acc0, D);

    fill(1'b1);
    rmode = 2;
    do_start(1'b1);
    wait_pix(2000, 8000);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rmode = 0;
    lat_chk = 1;
    do_start(1'b1);
    wait_done(5000);
    lat_chk = 0;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
